shift_word_rx: RTL and testbench

- Serial word receiver for the universal shift register's serial output.
- Recovers framed N-bit words from a 1-bit stream sampled on a bit strobe, in MSB-first (left-shift source) or LSB-first (right-shift source) order.
- Presents each completed word on a parallel output with a valid/ready handshake.
- Flags framing errors and overruns.
- Sits between a shift-register transmitter and downstream parallel logic in the same clock domain.

---
 rtl/shift_word_rx_if.sv | 20 ++
 rtl/shift_word_rx.sv | 54 +++++
 tb/tb_shift_word_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/shift_word_rx_if.sv
// shift_word_rx_if: serial-in strobe/bit-order controls plus parallel-out valid/ready bundle.
interface shift_word_rx_if #(parameter int N = 3);
    logic ser_in;
    logic ser_en;
    logic dir;
    logic [N-1:0] out;
    logic out_valid;
    logic out_ready;
    logic busy;
    logic frame_err;
    logic overrun;
    modport master (
        input ser_in, ser_en, dir, out_ready,
        output out, out_valid, busy, frame_err, overrun
    );
    modport slave (
        output ser_in, ser_en, dir, out_ready,
        input out, out_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/shift_word_rx.sv
// shift_word_rx: recovers start/data/stop framed N-bit words from a strobed serial line
// and presents them on a valid/ready parallel output with frame-error and overrun flags.
module shift_word_rx #(parameter int N = 3) (
    input logic clock,
    input logic clear,
    shift_word_rx_if.master bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic [N-1:0] shreg;
    logic dir_q;
    assign bus.busy = (state != IDLE);
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
            dir_q <= 1'b0;
            bus.out <= '0;
            bus.out_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            bus.frame_err <= 1'b0;
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            if (bus.ser_en) begin
                case (state)
                    IDLE: if (!bus.ser_in) begin
                        dir_q <= bus.dir;
                        count <= '0;
                        state <= DATA;
                    end
                    DATA: begin
                        shreg <= dir_q ? {bus.ser_in, shreg[N-1:1]} : {shreg[N-2:0], bus.ser_in};
                        count <= (count == CW'(N-1)) ? '0 : count + 1'b1;
                        state <= (count == CW'(N-1)) ? STOP : DATA;
                    end
                    STOP: begin
                        state <= IDLE;
                        // a consume on the same edge frees the slot, so the new word loads without a bubble
                        if (!bus.ser_in) bus.frame_err <= 1'b1;
                        else if (!bus.out_valid || bus.out_ready) begin
                            bus.out <= shreg;
                            bus.out_valid <= 1'b1;
                        end else bus.overrun <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_shift_word_rx.sv
// tb_shift_word_rx: directed test-plan frames plus randomized frames against a word-level model.
module tb_shift_word_rx;
    localparam int N = 3;
    logic clock;
    logic clear;
    int total = 0;
    int bad = 0;
    int busy_cnt;
    int ferr_cnt;
    shift_word_rx_if #(.N(N)) bus ();
    shift_word_rx #(.N(N)) dut (.clock(clock), .clear(clear), .bus(bus));
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
    task automatic step(input logic b, input logic en);
        bus.ser_in = b;
        bus.ser_en = en;
        @(posedge clock);
        @(negedge clock);
        busy_cnt += int'(bus.busy);
        ferr_cnt += int'(bus.frame_err);
        bus.ser_en = 1'b0;
    endtask
    // seq[4] is the first bit on the line (start), seq[0] the stop bit
    task automatic drive_seq(input logic [4:0] seq, input int gap, input logic tog, input logic rdy_stop);
        busy_cnt = 0;
        ferr_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (tog && k == 2) bus.dir = ~bus.dir;
            for (int g = 0; g < gap; g++) begin
                if (rdy_stop && k == 4 && g == 0) bus.out_ready = 1'b1;
                step(seq[4-k], g == 0);
                bus.out_ready = 1'b0;
            end
        end
    endtask
    task automatic pulse_reset();
        clear = 1'b0;
        step(1'b1, 1'b0);
        clear = 1'b1;
    endtask
    task automatic test_reset();
        clear = 1'b0;
        bus.ser_in = 1'b1;
        bus.ser_en = 1'b0;
        bus.dir = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (bus.out !== 3'b000) begin bad++; $display("FAIL reset_out: got %b want 000", bus.out); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
        clear = 1'b1;
        @(negedge clock);
    endtask
    task automatic test_msb();
        bus.dir = 1'b0;
        drive_seq(5'b00101, 1, 1'b0, 1'b0);
        total++; if (bus.out !== 3'b010) begin bad++; $display("FAIL msb_out: got %b want 010", bus.out); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL msb_valid: got %b want 1", bus.out_valid); end
        total++; if (busy_cnt != 4) begin bad++; $display("FAIL msb_busy_cycles: got %0d want 4", busy_cnt); end
        total++; if (ferr_cnt != 0) begin bad++; $display("FAIL msb_ferr: got %0d want 0", ferr_cnt); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL msb_ovr: got %b want 0", bus.overrun); end
        bus.out_ready = 1'b1;
        step(1'b1, 1'b0);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL msb_consume: got %b want 0", bus.out_valid); end
        total++; if (bus.out !== 3'b010) begin bad++; $display("FAIL msb_hold: got %b want 010", bus.out); end
    endtask
    task automatic test_lsb();
        bus.dir = 1'b1;
        drive_seq(5'b01101, 1, 1'b1, 1'b0);
        total++; if (bus.out !== 3'b011) begin bad++; $display("FAIL lsb_out: got %b want 011", bus.out); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid: got %b want 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        step(1'b1, 1'b0);
        bus.out_ready = 1'b0;
    endtask
    task automatic test_bad_stop();
        bus.dir = 1'b0;
        drive_seq(5'b01010, 1, 1'b0, 1'b0);
        total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL bad_ferr_high: got %b want 1", bus.frame_err); end
        step(1'b1, 1'b0);
        total++; if (ferr_cnt != 1) begin bad++; $display("FAIL bad_ferr_len: got %0d want 1", ferr_cnt); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bad_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bad_idle: got %b want 0", bus.busy); end
        drive_seq(5'b01111, 1, 1'b0, 1'b0);
        total++; if (bus.out !== 3'b111) begin bad++; $display("FAIL bad_next_out: got %b want 111", bus.out); end
        bus.out_ready = 1'b1;
        step(1'b1, 1'b0);
        bus.out_ready = 1'b0;
    endtask
    task automatic test_overrun();
        bus.dir = 1'b0;
        drive_seq(5'b01011, 1, 1'b0, 1'b0);
        drive_seq(5'b01101, 1, 1'b0, 1'b0);
        total++; if (bus.out !== 3'b101) begin bad++; $display("FAIL ovr_out: got %b want 101", bus.out); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
        bus.out_ready = 1'b1;
        step(1'b1, 1'b0);
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovr_consume: got %b want 0", bus.out_valid); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    endtask
    task automatic test_back_to_back();
        pulse_reset();
        bus.dir = 1'b0;
        drive_seq(5'b01011, 1, 1'b0, 1'b0);
        drive_seq(5'b01101, 1, 1'b0, 1'b1);
        total++; if (bus.out !== 3'b110) begin bad++; $display("FAIL b2b_out: got %b want 110", bus.out); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", bus.out_valid); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr: got %b want 0", bus.overrun); end
    endtask
    task automatic test_sparse_reset();
        pulse_reset();
        bus.dir = 1'b0;
        drive_seq(5'b00101, 3, 1'b0, 1'b0);
        total++; if (bus.out !== 3'b010) begin bad++; $display("FAIL sparse_out: got %b want 010", bus.out); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sparse_valid: got %b want 1", bus.out_valid); end
        total++; if (busy_cnt != 12) begin bad++; $display("FAIL sparse_busy_cycles: got %0d want 12", busy_cnt); end
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
        #2 clear = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", bus.busy); end
        total++; if (bus.out !== 3'b000) begin bad++; $display("FAIL async_out: got %b want 000", bus.out); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", bus.out_valid); end
        @(negedge clock);
        clear = 1'b1;
        drive_seq(5'b01101, 1, 1'b0, 1'b0);
        total++; if (bus.out !== 3'b110) begin bad++; $display("FAIL post_reset_out: got %b want 110", bus.out); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid: got %b want 1", bus.out_valid); end
    endtask
    // word-level model: a frame carrying word w in order d must reproduce w; delivery follows the slot rules
    task automatic test_random();
        logic [N-1:0] w, eo;
        logic d, good, ev, eov, ef, eb, en, b;
        int gap;
        pulse_reset();
        eo = '0; ev = 1'b0; eov = 1'b0;
        for (int f = 0; f < 40; f++) begin
            w = N'($urandom);
            d = 1'($urandom);
            good = ($urandom_range(0, 7) != 0);
            gap = $urandom_range(1, 3);
            for (int k = 0; k < N + 2; k++) begin
                for (int g = 0; g < gap; g++) begin
                    b = (k == 0) ? 1'b0 : (k == N + 1) ? good : (d ? w[k-1] : w[N-k]);
                    bus.dir = (k == 0) ? d : 1'($urandom);
                    bus.out_ready = ($urandom_range(0, 3) == 0);
                    en = (g == 0);
                    if (en && k == N + 1 && good) begin
                        if (!ev || bus.out_ready) begin eo = w; ev = 1'b1; end
                        else eov = 1'b1;
                    end else if (ev && bus.out_ready) ev = 1'b0;
                    ef = en && k == N + 1 && !good;
                    eb = (k <= N);
                    step(b, en);
                    total++; if (bus.out_valid !== ev) begin bad++; $display("FAIL rnd_valid f%0d: got %b want %b", f, bus.out_valid, ev); end
                    total++; if (bus.out !== eo) begin bad++; $display("FAIL rnd_out f%0d: got %b want %b", f, bus.out, eo); end
                    total++; if (bus.overrun !== eov) begin bad++; $display("FAIL rnd_ovr f%0d: got %b want %b", f, bus.overrun, eov); end
                    total++; if (bus.frame_err !== ef) begin bad++; $display("FAIL rnd_ferr f%0d: got %b want %b", f, bus.frame_err, ef); end
                    total++; if (bus.busy !== eb) begin bad++; $display("FAIL rnd_busy f%0d: got %b want %b", f, bus.busy, eb); end
                end
            end
        end
        bus.out_ready = 1'b0;
    endtask
    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_bad_stop();
        test_overrun();
        test_back_to_back();
        test_sparse_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
